// File: rtl/channel_ram_reader.sv
// Frame reader for the dual-port channel-sample RAM: issues even/odd address pairs,
// realigns read data with valid strobes and steps a wrapping frame base pointer.
module channel_ram_reader #(
    parameter int unsigned CodeLen       = 256,
    parameter int unsigned RAM_Depth     = 4096,
    parameter int unsigned RAM_Addr_bits = 12,
    parameter int unsigned RAM_Latency   = 1,
    parameter int unsigned Data_Width    = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     demodulation_read_RAM,
    output logic                     RAM_read_receive,
    output logic                     ena,
    output logic [RAM_Addr_bits-1:0] addra,
    output logic                     enb,
    output logic [RAM_Addr_bits-1:0] addrb,
    input  logic [Data_Width-1:0]    ram_douta,
    input  logic [Data_Width-1:0]    ram_doutb,
    output logic                     demodulation_valid_a,
    output logic                     demodulation_valid_b,
    output logic [Data_Width-1:0]    douta,
    output logic [Data_Width-1:0]    doutb,
    output logic [15:0]              frame_count
);

    localparam int unsigned Pairs = CodeLen / 2;
    localparam int unsigned CntW  = $clog2(Pairs + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [RAM_Addr_bits-1:0] base_q, base_d;
    logic [CntW-1:0]          pair_q, pair_d;
    logic                     ack_q, ack_d;
    logic                     en_q, en_d;
    logic [RAM_Addr_bits-1:0] addra_q, addra_d;
    logic [RAM_Addr_bits-1:0] addrb_q, addrb_d;
    logic [RAM_Latency-1:0]   vpipe_q, vpipe_d;
    logic                     valid_q, valid_d;
    logic [Data_Width-1:0]    douta_q, douta_d;
    logic [Data_Width-1:0]    doutb_q, doutb_d;
    logic [15:0]              fcount_q, fcount_d;
    logic [RAM_Addr_bits-1:0] offs;

    // Next-state, address generation and read-data realignment
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        pair_d   = pair_q;
        ack_d    = 1'b0;
        en_d     = 1'b0;
        addra_d  = addra_q;
        addrb_d  = addrb_q;
        fcount_d = fcount_q;
        offs     = RAM_Addr_bits'({pair_q, 1'b0});

        // vpipe_q[i] carries the enable delayed by i+1 cycles; the top tap marks
        // the cycle in which the RAM data for that enable is present.
        vpipe_d = RAM_Latency'({vpipe_q, en_q});
        valid_d = vpipe_q[RAM_Latency-1];
        douta_d = vpipe_q[RAM_Latency-1] ? ram_douta : douta_q;
        doutb_d = vpipe_q[RAM_Latency-1] ? ram_doutb : doutb_q;

        case (state_q)
            IDLE: begin
                if (demodulation_read_RAM) begin
                    ack_d   = 1'b1;
                    en_d    = 1'b1;
                    addra_d = base_q;
                    addrb_d = base_q + RAM_Addr_bits'(1);
                    pair_d  = CntW'(1);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (pair_q == CntW'(Pairs)) begin
                    pair_d  = '0;
                    state_d = DRAIN;
                end else begin
                    en_d    = 1'b1;
                    addra_d = base_q + offs;
                    addrb_d = base_q + offs + RAM_Addr_bits'(1);
                    pair_d  = pair_q + CntW'(1);
                end
            end
            DRAIN: begin
                // Leave only once the final strobe has already been presented
                if ((vpipe_q == '0) && !valid_q) begin
                    base_d   = RAM_Addr_bits'((32'(base_q) + CodeLen) % RAM_Depth);
                    fcount_d = fcount_q + 16'd1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            base_q   <= '0;
            pair_q   <= '0;
            ack_q    <= 1'b0;
            en_q     <= 1'b0;
            addra_q  <= '0;
            addrb_q  <= '0;
            vpipe_q  <= '0;
            valid_q  <= 1'b0;
            douta_q  <= '0;
            doutb_q  <= '0;
            fcount_q <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            pair_q   <= pair_d;
            ack_q    <= ack_d;
            en_q     <= en_d;
            addra_q  <= addra_d;
            addrb_q  <= addrb_d;
            vpipe_q  <= vpipe_d;
            valid_q  <= valid_d;
            douta_q  <= douta_d;
            doutb_q  <= doutb_d;
            fcount_q <= fcount_d;
        end
    end

    assign RAM_read_receive     = ack_q;
    assign ena                  = en_q;
    assign enb                  = en_q;
    assign addra                = addra_q;
    assign addrb                = addrb_q;
    assign demodulation_valid_a = valid_q;
    assign demodulation_valid_b = valid_q;
    assign douta                = douta_q;
    assign doutb                = doutb_q;
    assign frame_count          = fcount_q;

endmodule
